out_port_arbiter: RTL and testbench

- Synchronous packet-level allocator for one output port of the asynchronous bundled-data crossbar.
- Chooses among the PORTS_G+PORTS_L-1 input ports competing for this output using round-robin.
- Asserts exactly one PacketEnable line for the chosen input and holds the grant until the downstream Tailpassed handshake completes.
- One instance per output port; its PacketEnable_o feeds the crossbar's PacketEnable_up inputs for that output.

---
 rtl/noc_arb_pkg.sv | 58 +++++
 rtl/tail_sync.sv | 47 ++++
 rtl/out_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_out_port_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_arb_pkg.sv
// -----------------------------------------------------------------------------
// noc_arb_pkg
// Shared types and helpers for the per-output-port packet arbiter of the
// asynchronous bundled-data crossbar.
//   arb_state_t       : allocator FSM states (IDLE, GRANT, DRAIN)
//   SYNC_STAGES       : depth of the Tailpassed synchronizer
//   WD_CYCLES_DEFAULT : default watchdog limit in clock cycles
//   rr_pick()         : round-robin winner search starting after ptr
// -----------------------------------------------------------------------------
package noc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int SYNC_STAGES       = 2;
    localparam int WD_CYCLES_DEFAULT = 1024;

    // rr_pick works on a fixed maximum vector; callers zero-extend.
    localparam int MAX_PORTS = 32;
    localparam int PICK_W    = 5;

    // Returns the first set bit of cand searching ptr+1, ptr+2, ... modulo n.
    // With cand all-zero the result is ptr; callers qualify with |cand.
    function automatic logic [PICK_W-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] cand,
        input logic [PICK_W-1:0]    ptr,
        input int                   n
    );
        int                idx;
        logic              found;
        logic [PICK_W-1:0] win;
        found = 1'b0;
        win   = ptr;
        for (int k = 1; k <= MAX_PORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) begin
                idx = idx - n;
            end else begin
                idx = idx;
            end
            if (k <= n) begin
                if (!found && cand[idx]) begin
                    win   = idx[PICK_W-1:0];
                    found = 1'b1;
                end else begin
                    found = found;
                end
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/tail_sync.sv
// -----------------------------------------------------------------------------
// tail_sync
// Multi-flop synchronizer for an asynchronous 4-phase level, followed by a
// rise/fall detector on the synchronized level. Reusable for any
// async-to-sync handshake line.
// Ports:
//   clk_i   : destination clock
//   rst_i   : asynchronous active-high reset, clears every flop
//   async_i : asynchronous level input
//   level_o : synchronized level
//   rise_o  : one-cycle pulse when the synchronized level goes 0->1
//   fall_o  : one-cycle pulse when the synchronized level goes 1->0
// -----------------------------------------------------------------------------
module tail_sync
    import noc_arb_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Edges are derived only from flops, so both pulses are glitch-free and
    // can never be high together.
    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/out_port_arbiter.sv
// -----------------------------------------------------------------------------
// out_port_arbiter
// Packet-level round-robin allocator for one output port of the asynchronous
// bundled-data crossbar. One grant is held from selection until the
// downstream Tailpassed 4-phase handshake completes.
// Optional build macro: ARB_WATCHDOG_EN (forced release after WD_CYCLES
// cycles in GRANT, sticky timeout_o).
// Ports:
//   clk_i          : clock
//   rst_i          : asynchronous active-high reset
//   req_i[N]       : per-input packet request (level, clk_i domain)
//   mask_i[N]      : per-input enable (1 = may be granted)
//   tailpassed_i   : downstream Tailpassed, asynchronous 4-phase level
//   PacketEnable_o : registered one-hot grant, zero when idle
//   grant_idx_o    : index of the current or last grant
//   busy_o         : high in GRANT and DRAIN
//   timeout_o      : sticky watchdog flag (0 without ARB_WATCHDOG_EN)
// -----------------------------------------------------------------------------
module out_port_arbiter
    import noc_arb_pkg::*;
#(
    parameter  int PORTS_G   = 4,
    parameter  int PORTS_L   = 1,
    parameter  int WD_CYCLES = WD_CYCLES_DEFAULT,
    localparam int N         = PORTS_G + PORTS_L - 1,
    localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic          tailpassed_i,
    output logic [N-1:0]  PacketEnable_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          busy_o,
    output logic          timeout_o
);

    arb_state_t     state_q;
    logic [IW-1:0]  ptr_q;
    logic [N-1:0]   pe_q;
    logic [IW-1:0]  gidx_q;
    logic           busy_q;

    logic [N-1:0]         cand_d;
    logic [MAX_PORTS-1:0] cand_ext_d;
    logic [IW-1:0]        pick_d;
    logic [N-1:0]         onehot_d;

    logic tail_lvl_s;
    logic tail_r_s;
    logic tail_f_s;

    tail_sync #(
        .STAGES (SYNC_STAGES)
    ) u_tail_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (tailpassed_i),
        .level_o (tail_lvl_s),
        .rise_o  (tail_r_s),
        .fall_o  (tail_f_s)
    );

    // Eligible requesters and their round-robin winner, one-hot encoded.
    always_comb begin
        cand_d                = req_i & mask_i;
        cand_ext_d            = {MAX_PORTS{1'b0}};
        cand_ext_d[N-1:0]     = cand_d;
        pick_d                = IW'(rr_pick(cand_ext_d, PICK_W'(ptr_q), N));
        onehot_d              = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            onehot_d[i] = (pick_d == IW'(i));
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int            WD_W    = $clog2(WD_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            timeout_q;
`else
    // WD_CYCLES only matters with the watchdog built in.
    logic unused_wd_cfg_s;
    assign unused_wd_cfg_s = (WD_CYCLES > 32'sd0) ? 1'b1 : 1'b0;
`endif

    // Allocator FSM; every output is a flop so grants never follow inputs
    // combinationally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(N - 1);
            pe_q      <= {N{1'b0}};
            gidx_q    <= {IW{1'b0}};
            busy_q    <= 1'b0;
`ifdef ARB_WATCHDOG_EN
            wd_cnt_q  <= {WD_W{1'b0}};
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // Tail edges arriving here are stale and deliberately ignored.
                    if (|cand_d) begin
                        pe_q     <= onehot_d;
                        gidx_q   <= pick_d;
                        busy_q   <= 1'b1;
                        state_q  <= GRANT;
`ifdef ARB_WATCHDOG_EN
                        wd_cnt_q <= {WD_W{1'b0}};
`endif
                    end
                end
                GRANT: begin
                    // Packet-level lock: req_i/mask_i are not looked at here.
                    if (tail_r_s) begin
                        pe_q    <= {N{1'b0}};
                        ptr_q   <= gidx_q;
                        state_q <= DRAIN;
                    end
`ifdef ARB_WATCHDOG_EN
                    else if (wd_cnt_q == WD_LAST) begin
                        // Forced release skips DRAIN: no handshake to finish.
                        pe_q      <= {N{1'b0}};
                        ptr_q     <= gidx_q;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + {{(WD_W-1){1'b0}}, 1'b1};
                    end
`endif
                end
                DRAIN: begin
                    // Return-to-zero phase of the 4-phase handshake.
                    if (tail_f_s || !tail_lvl_s) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    pe_q    <= {N{1'b0}};
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign PacketEnable_o = pe_q;
    assign grant_idx_o    = gidx_q;
    assign busy_o         = busy_q;
`ifdef ARB_WATCHDOG_EN
    assign timeout_o      = timeout_q;
`else
    assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_out_port_arbiter.sv
module tb_out_port_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = 4'b0000;
    logic [N-1:0] mask = 4'b1111;
    logic         tail = 1'b0;
    logic [N-1:0] pe;
    logic [1:0]   gidx;
    logic         busy;
    logic         timeout;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    out_port_arbiter #(
        .PORTS_G   (4),
        .PORTS_L   (1),
        .WD_CYCLES (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .mask_i         (mask),
        .tailpassed_i   (tail),
        .PacketEnable_o (pe),
        .grant_idx_o    (gidx),
        .busy_o         (busy),
        .timeout_o      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for a grant, then compares it to the scoreboard head.
    task automatic wait_grant(input string tag);
        bit found;
        int e;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (pe !== 4'b0000) found = 1'b1;
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
        check({tag, "_sb"}, 32'(exp_q.size() > 0), 32'd1);
        if (found && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_pe"}, 32'(pe), 32'd1 << e);
            check({tag, "_idx"}, 32'(gidx), 32'(e));
            check({tag, "_busy"}, 32'(busy), 32'd1);
        end
    endtask

    // Full 4-phase Tailpassed handshake with bounded waits.
    task automatic do_tail(input string tag);
        bit ok;
        ok = 1'b0;
        tail = 1'b1;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (pe === 4'b0000) ok = 1'b1;
        end
        check({tag, "_release"}, 32'(ok), 32'd1);
        check({tag, "_drain_busy"}, 32'(busy), 32'd1);
        tail = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1'b1;
        end
        check({tag, "_idle"}, 32'(ok), 32'd1);
        check({tag, "_gap"}, 32'(pe), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int e;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pe", 32'(pe), 32'd0);
        check("rst_idx", 32'(gidx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);

        // Single request, one-cycle latency
        rst = 1'b0;
        req = 4'b0100;
        exp_q.push_back(2);
        @(negedge clk);
        e = exp_q.pop_front();
        check("t1_pe", 32'(pe), 32'd1 << e);
        check("t1_idx", 32'(gidx), 32'(e));
        check("t1_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        do_tail("t1");

        // Round-robin fairness from a fresh pointer
        do_reset();
        req = 4'b1111;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        for (int i = 0; i < 5; i++) begin
            wait_grant("rr");
            if (i == 4) req = 4'b0000;
            do_tail("rr");
        end

        // Masking plus back-to-back single requester
        req = 4'b1010;
        mask = 4'b0010;
        exp_q.push_back(1);
        exp_q.push_back(1);
        wait_grant("mask1");
        do_tail("mask1");
        wait_grant("mask2");
        mask = 4'b0000;
        do_tail("mask2");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mask_none", 32'(pe), 32'd0);
        end
        req = 4'b0000;
        mask = 4'b1111;

        // Packet lock, then reset mid-grant
        do_reset();
        req = 4'b0001;
        exp_q.push_back(0);
        wait_grant("lock");
        req = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lock_hold", 32'(pe), 32'd1);
        end
        rst = 1'b1;
        #1;
        check("midrst_pe", 32'(pe), 32'd0);
        check("midrst_idx", 32'(gidx), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_timeout", 32'(timeout), 32'd0);
        repeat (2) @(negedge clk);
        req = 4'b1001;
        exp_q.push_back(0);
        rst = 1'b0;
        wait_grant("postrst");
        req = 4'b0000;
        do_tail("postrst");

        // Spurious tail toggles while idle
        tail = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("spur_hi_pe", 32'(pe), 32'd0);
            check("spur_hi_busy", 32'(busy), 32'd0);
        end
        tail = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("spur_lo_pe", 32'(pe), 32'd0);
            check("spur_lo_busy", 32'(busy), 32'd0);
        end
        req = 4'b0100;
        exp_q.push_back(2);
        wait_grant("spur_after");
        req = 4'b0000;
        do_tail("spur_after");

`ifdef ARB_WATCHDOG_EN
        // Watchdog forced release after 16 cycles in GRANT
        do_reset();
        req = 4'b0010;
        exp_q.push_back(1);
        wait_grant("wd");
        req = 4'b0110;
        begin
            int held;
            held = 1;
            while (pe !== 4'b0000 && held < 40) begin
                @(negedge clk);
                if (pe !== 4'b0000) held++;
            end
            check("wd_held_cycles", 32'(held), 32'd16);
        end
        check("wd_pe", 32'(pe), 32'd0);
        check("wd_timeout", 32'(timeout), 32'd1);
        exp_q.push_back(2);
        wait_grant("wd_next");
        req = 4'b0000;
        do_tail("wd_next");
        check("wd_sticky", 32'(timeout), 32'd1);
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
